// File: rtl/pipeline_controller.sv
// Hazard/stall/flush/forward control for a 5-stage IF/ID/EX/MEM/WB pipeline; holds no datapath values.
// Define PIPE_FORWARDING_EN to resolve RAW hazards by forwarding (load-use stalls only).
module pipeline_controller #(
  parameter int unsigned StallCntW = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 if_valid_i,
  input  logic [3:0]           id_rn_i,
  input  logic [3:0]           id_rm_i,
  input  logic [3:0]           id_rs_i,
  input  logic                 id_use_rn_i,
  input  logic                 id_use_rm_i,
  input  logic                 id_use_rs_i,
  input  logic [3:0]           id_rd_i,
  input  logic                 id_wr_i,
  input  logic                 id_load_i,
  input  logic                 ex_br_taken_i,
  input  logic                 mem_busy_i,
  output logic                 pc_en_o,
  output logic                 pc_sel_br_o,
  output logic                 if_id_en_o,
  output logic                 id_ex_en_o,
  output logic                 ex_mem_en_o,
  output logic                 mem_wb_en_o,
  output logic                 v_id_o,
  output logic                 v_ex_o,
  output logic                 v_mem_o,
  output logic                 v_wb_o,
  output logic [1:0]           fwd_rn_sel_o,
  output logic [1:0]           fwd_rm_sel_o,
  output logic [1:0]           fwd_rs_sel_o,
  output logic [StallCntW-1:0] stall_cnt_o
);

  logic                 v_id_q, v_id_d;
  logic                 v_ex_q, v_ex_d;
  logic                 v_mem_q, v_mem_d;
  logic                 v_wb_q, v_wb_d;
  logic [3:0]           ex_rd_q, ex_rd_d, mem_rd_q, mem_rd_d, wb_rd_q, wb_rd_d;
  logic                 ex_wr_q, ex_wr_d, mem_wr_q, mem_wr_d, wb_wr_q, wb_wr_d;
  logic                 br_pend_q, br_pend_d;
  logic                 first_q;
  logic [StallCntW-1:0] cnt_q, cnt_d;
  logic [2:0][1:0]      fwd_q, fwd_d, fwd_sel;

  logic [2:0][3:0]      src;
  logic [2:0]           use_src;
  logic [2:0]           hit_ex, hit_mem, hit_wb;
  logic                 hazard, freeze, br_now, flush, stall;

  assign src     = {id_rs_i, id_rm_i, id_rn_i};
  assign use_src = {id_use_rs_i, id_use_rm_i, id_use_rn_i};

  // R15 reads come from the PC, never from a producer in flight.
  function automatic logic src_match(input logic v, input logic wr, input logic [3:0] rd,
                                     input logic [3:0] s, input logic use_s);
    return v && wr && use_s && (rd == s) && (s != 4'd15);
  endfunction

  always_comb begin
    hit_ex  = '0;
    hit_mem = '0;
    hit_wb  = '0;
    for (int i = 0; i < 3; i++) begin
      hit_ex[i]  = v_id_q && src_match(v_ex_q, ex_wr_q, ex_rd_q, src[i], use_src[i]);
      hit_mem[i] = v_id_q && src_match(v_mem_q, mem_wr_q, mem_rd_q, src[i], use_src[i]);
      hit_wb[i]  = v_id_q && src_match(v_wb_q, wb_wr_q, wb_rd_q, src[i], use_src[i]);
    end
  end

`ifdef PIPE_FORWARDING_EN
  logic ex_load_q, ex_load_d;
  logic unused_wb_hit;
  assign unused_wb_hit = |hit_wb;

  always_comb begin
    hazard = ex_load_q && (|hit_ex);
    for (int i = 0; i < 3; i++) begin
      fwd_sel[i] = hit_ex[i] ? 2'd1 : (hit_mem[i] ? 2'd2 : 2'd0);
    end
  end
`else
  logic unused_load;
  assign unused_load = id_load_i;

  always_comb begin
    hazard  = |{hit_ex, hit_mem, hit_wb};
    fwd_sel = '0;
  end
`endif

  always_comb begin
    freeze = mem_busy_i;
    br_now = (ex_br_taken_i || br_pend_q) && v_ex_q;
    flush  = !freeze && br_now;
    stall  = !freeze && !flush && hazard;
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v_id_q    <= 1'b0;
      v_ex_q    <= 1'b0;
      v_mem_q   <= 1'b0;
      v_wb_q    <= 1'b0;
      ex_rd_q   <= '0;
      mem_rd_q  <= '0;
      wb_rd_q   <= '0;
      ex_wr_q   <= 1'b0;
      mem_wr_q  <= 1'b0;
      wb_wr_q   <= 1'b0;
      br_pend_q <= 1'b0;
      first_q   <= 1'b1;
      cnt_q     <= '0;
      fwd_q     <= '0;
`ifdef PIPE_FORWARDING_EN
      ex_load_q <= 1'b0;
`endif
    end else begin
      v_id_q    <= v_id_d;
      v_ex_q    <= v_ex_d;
      v_mem_q   <= v_mem_d;
      v_wb_q    <= v_wb_d;
      ex_rd_q   <= ex_rd_d;
      mem_rd_q  <= mem_rd_d;
      wb_rd_q   <= wb_rd_d;
      ex_wr_q   <= ex_wr_d;
      mem_wr_q  <= mem_wr_d;
      wb_wr_q   <= wb_wr_d;
      br_pend_q <= br_pend_d;
      first_q   <= 1'b0;
      cnt_q     <= cnt_d;
      fwd_q     <= fwd_d;
`ifdef PIPE_FORWARDING_EN
      ex_load_q <= ex_load_d;
`endif
    end
  end

  // Next-state
  always_comb begin
    v_id_d    = v_id_q;
    v_ex_d    = v_ex_q;
    v_mem_d   = v_mem_q;
    v_wb_d    = v_wb_q;
    ex_rd_d   = ex_rd_q;
    mem_rd_d  = mem_rd_q;
    wb_rd_d   = wb_rd_q;
    ex_wr_d   = ex_wr_q;
    mem_wr_d  = mem_wr_q;
    wb_wr_d   = wb_wr_q;
    cnt_d     = cnt_q;
    fwd_d     = fwd_q;
    br_pend_d = 1'b0;
`ifdef PIPE_FORWARDING_EN
    ex_load_d = ex_load_q;
`endif
    if (freeze) begin
      br_pend_d = br_pend_q || (ex_br_taken_i && v_ex_q);
    end else begin
      v_wb_d   = v_mem_q;
      wb_rd_d  = mem_rd_q;
      wb_wr_d  = mem_wr_q;
      v_mem_d  = v_ex_q;
      mem_rd_d = ex_rd_q;
      mem_wr_d = ex_wr_q;
      if (flush) begin
        v_id_d = 1'b0;
        v_ex_d = 1'b0;
        fwd_d  = '0;
      end else if (stall) begin
        v_ex_d = 1'b0;
        fwd_d  = '0;
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
      end else begin
        v_id_d  = if_valid_i;
        v_ex_d  = v_id_q;
        ex_rd_d = id_rd_i;
        ex_wr_d = id_wr_i;
        fwd_d   = fwd_sel;
`ifdef PIPE_FORWARDING_EN
        ex_load_d = id_load_i;
`endif
      end
    end
  end

  // Outputs
  always_comb begin
    pc_en_o     = 1'b0;
    pc_sel_br_o = 1'b0;
    if_id_en_o  = 1'b0;
    id_ex_en_o  = 1'b0;
    ex_mem_en_o = 1'b0;
    mem_wb_en_o = 1'b0;
    if (rst_i) begin
      pc_en_o = 1'b1;
    end else if (freeze) begin
      pc_en_o = 1'b0;
    end else if (flush) begin
      pc_en_o     = 1'b1;
      pc_sel_br_o = 1'b1;
      if_id_en_o  = 1'b1;
      id_ex_en_o  = 1'b1;
      ex_mem_en_o = 1'b1;
      mem_wb_en_o = 1'b1;
    end else if (stall) begin
      id_ex_en_o  = 1'b1;
      ex_mem_en_o = 1'b1;
      mem_wb_en_o = 1'b1;
    end else begin
      // A missing fetch retries the same PC, except right after reset.
      pc_en_o     = if_valid_i || first_q;
      if_id_en_o  = 1'b1;
      id_ex_en_o  = 1'b1;
      ex_mem_en_o = 1'b1;
      mem_wb_en_o = 1'b1;
    end
  end

  assign v_id_o       = v_id_q;
  assign v_ex_o       = v_ex_q;
  assign v_mem_o      = v_mem_q;
  assign v_wb_o       = v_wb_q;
  assign fwd_rn_sel_o = fwd_q[0];
  assign fwd_rm_sel_o = fwd_q[1];
  assign fwd_rs_sel_o = fwd_q[2];
  assign stall_cnt_o  = cnt_q;

endmodule
